// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: drives register file reads/writes, tracks per-register busy
// bits to stall RAW/WAW hazards, and holds one issued instruction for execute.
module operand_fetch_unit #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [ADDR_W-1:0]   iss_src_a,
    input  logic [ADDR_W-1:0]   iss_src_b,
    input  logic [ADDR_W-1:0]   iss_dst,
    input  logic                iss_wr_en,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [DATA_W-1:0]   ex_op_a,
    output logic [DATA_W-1:0]   ex_op_b,
    output logic [ADDR_W-1:0]   ex_dst,
    output logic                ex_wr_en,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                rf_write,
    output logic [ADDR_W-1:0]   rf_wr_addr,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic [ADDR_W-1:0]   rf_rd_addr_a,
    input  logic [DATA_W-1:0]   rf_rd_data_a,
    output logic [ADDR_W-1:0]   rf_rd_addr_b,
    input  logic [DATA_W-1:0]   rf_rd_data_b,
    output logic [NUM_REGS-1:0] busy,
    output logic [7:0]          stall_cnt,
    output logic                wb_err
);

    typedef enum logic {StEmpty, StFull} state_t;

    // Extra bit so the compare stays valid when NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]   op_a_q, op_b_q;
    logic [ADDR_W-1:0]   dst_q;
    logic                wr_en_q;
    logic [7:0]          stall_q;
    logic                wb_err_q;

    logic                impl_a, impl_b, impl_d, impl_wb;
    logic                hit_a, hit_b, hit_d;
    logic                haz_a, haz_b, haz_waw;
    logic                can_load, accept;
    logic [DATA_W-1:0]   sel_a, sel_b;

    function automatic logic is_impl(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NumRegsW;
    endfunction

    // Loop lookup avoids indexing busy with an address wider than its range.
    function automatic logic reg_busy(input logic [NUM_REGS-1:0] b,
                                      input logic [ADDR_W-1:0]   a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (a == ADDR_W'(i)) r = b[i];
        end
        return r;
    endfunction

    // Register file pass-through and hazard/operand selection.
    always_comb begin
        rf_rd_addr_a = iss_src_a;
        rf_rd_addr_b = iss_src_b;
        rf_write     = wb_valid;
        rf_wr_addr   = wb_addr;
        rf_wr_data   = wb_data;

        impl_a  = is_impl(iss_src_a);
        impl_b  = is_impl(iss_src_b);
        impl_d  = is_impl(iss_dst);
        impl_wb = is_impl(wb_addr);
        hit_a   = wb_valid && (wb_addr == iss_src_a);
        hit_b   = wb_valid && (wb_addr == iss_src_b);
        hit_d   = wb_valid && (wb_addr == iss_dst);

        haz_a   = impl_a && reg_busy(busy_q, iss_src_a) && !hit_a;
        haz_b   = impl_b && reg_busy(busy_q, iss_src_b) && !hit_b;
        haz_waw = iss_wr_en && impl_d && reg_busy(busy_q, iss_dst) && !hit_d;

        sel_a = !impl_a ? '0 : (hit_a ? wb_data : rf_rd_data_a);
        sel_b = !impl_b ? '0 : (hit_b ? wb_data : rf_rd_data_b);

        can_load  = (state_q == StEmpty) || ex_ready;
        iss_ready = can_load && !haz_a && !haz_b && !haz_waw;
        accept    = iss_valid && iss_ready;
    end

    // Output stage next state and scoreboard update (set beats same-cycle clear).
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StFull;
        end else if ((state_q == StFull) && ex_ready) begin
            state_d = StEmpty;
        end

        busy_d = busy_q;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (wb_valid && (wb_addr == ADDR_W'(i))) busy_d[i] = 1'b0;
            if (accept && iss_wr_en && (iss_dst == ADDR_W'(i))) busy_d[i] = 1'b1;
        end
    end

    // State, scoreboard, stall counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            busy_q   <= '0;
            stall_q  <= '0;
            wb_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (iss_valid && !iss_ready && (stall_q != 8'hFF)) stall_q <= stall_q + 8'd1;
            if (wb_valid && impl_wb && !reg_busy(busy_q, wb_addr)) wb_err_q <= 1'b1;
        end
    end

    // Execute payload; only written on accept so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            dst_q   <= '0;
            wr_en_q <= 1'b0;
        end else if (accept) begin
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            dst_q   <= iss_dst;
            wr_en_q <= iss_wr_en;
        end
    end

    assign ex_valid  = (state_q == StFull);
    assign ex_op_a   = op_a_q;
    assign ex_op_b   = op_b_q;
    assign ex_dst    = dst_q;
    assign ex_wr_en  = wr_en_q;
    assign busy      = busy_q;
    assign stall_cnt = stall_q;
    assign wb_err    = wb_err_q;

endmodule
